// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-Wire slave layers: ROM command codes,
// ROM-layer state encoding and the ID byte selector.
package onewire_pkg;

  localparam logic [7:0] CMD_READ_ROM  = 8'h33;
  localparam logic [7:0] CMD_MATCH_ROM = 8'h55;
  localparam logic [7:0] CMD_SKIP_ROM  = 8'hCC;

  localparam int unsigned ID_BYTES = 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ROM_CMD    = 3'd1,
    ST_READ_ROM   = 3'd2,
    ST_MATCH_ROM  = 3'd3,
    ST_SELECTED   = 3'd4,
    ST_DESELECTED = 3'd5
  } rom_state_t;

  // Byte 0 is the family code and goes out first on the wire.
  function automatic logic [7:0] id_byte(input logic [63:0] id, input logic [2:0] idx);
    return id[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/onewire_edge_detect.sv
// Registered rising-edge detector: one-cycle pulse the cycle after a level rises.
module onewire_edge_detect
  import onewire_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_r;
  logic pulse_r;

  // Delay the level once and flag the 0->1 transition a cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_r <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      level_r <= level;
      pulse_r <= level & ~level_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/onewire_rom_layer.sv
// ROM-command layer of the 1-Wire slave: decodes READ/MATCH/SKIP ROM after each
// bus reset and forwards function bytes once the device is selected.
module onewire_rom_layer
  import onewire_pkg::*;
#(
  parameter logic [63:0] ROM_ID = 64'h5A00_0000_0012_3428
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line_reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_finished,
  input  logic       tx_done,
  output logic [7:0] tx_byte,
  output logic       direction,
  output logic       tx_load,
  output logic       selected,
  output logic [7:0] func_byte,
  output logic       func_valid
);

  logic       rx_ev_s;
  rom_state_t state_r;
  logic [2:0] index_r;
  logic [7:0] tx_byte_r;
  logic       direction_r;
  logic       tx_load_r;
  logic       selected_r;
  logic [7:0] func_byte_r;
  logic       func_valid_r;

  onewire_edge_detect u_rx_edge (
    .clk   (clk),
    .reset (reset),
    .level (rx_finished),
    .pulse (rx_ev_s)
  );

  // ROM-layer FSM with index counter, ID byte mux and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      index_r      <= 3'd0;
      tx_byte_r    <= 8'h00;
      direction_r  <= 1'b0;
      tx_load_r    <= 1'b0;
      selected_r   <= 1'b0;
      func_byte_r  <= 8'h00;
      func_valid_r <= 1'b0;
    end else if (line_reset) begin
      // A bus reset aborts whatever was in flight, including a same-cycle event.
      state_r      <= ST_ROM_CMD;
      index_r      <= 3'd0;
      direction_r  <= 1'b0;
      tx_load_r    <= 1'b0;
      selected_r   <= 1'b0;
      func_valid_r <= 1'b0;
    end else begin
      tx_load_r    <= 1'b0;
      func_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        ST_ROM_CMD: begin
          if (rx_ev_s) begin
            case (rx_byte)
              CMD_READ_ROM: begin
                state_r     <= ST_READ_ROM;
                index_r     <= 3'd0;
                tx_byte_r   <= id_byte(ROM_ID, 3'd0);
                direction_r <= 1'b1;
                tx_load_r   <= 1'b1;
              end
              CMD_MATCH_ROM: begin
                state_r <= ST_MATCH_ROM;
                index_r <= 3'd0;
              end
              CMD_SKIP_ROM: begin
                state_r    <= ST_SELECTED;
                selected_r <= 1'b1;
              end
              default: begin
                state_r <= ST_DESELECTED;
              end
            endcase
          end else begin
            state_r <= ST_ROM_CMD;
          end
        end
        ST_READ_ROM: begin
          if (tx_done) begin
            if (index_r == 3'd7) begin
              state_r     <= ST_SELECTED;
              direction_r <= 1'b0;
              selected_r  <= 1'b1;
            end else begin
              index_r   <= index_r + 3'd1;
              tx_byte_r <= id_byte(ROM_ID, index_r + 3'd1);
              tx_load_r <= 1'b1;
            end
          end else begin
            state_r <= ST_READ_ROM;
          end
        end
        ST_MATCH_ROM: begin
          if (rx_ev_s) begin
            if (rx_byte != id_byte(ROM_ID, index_r)) begin
              state_r <= ST_DESELECTED;
            end else if (index_r == 3'd7) begin
              state_r    <= ST_SELECTED;
              selected_r <= 1'b1;
            end else begin
              index_r <= index_r + 3'd1;
            end
          end else begin
            state_r <= ST_MATCH_ROM;
          end
        end
        ST_SELECTED: begin
          if (rx_ev_s) begin
            func_byte_r  <= rx_byte;
            func_valid_r <= 1'b1;
          end else begin
            func_valid_r <= 1'b0;
          end
        end
        ST_DESELECTED: begin
          state_r <= ST_DESELECTED;
        end
        default: begin
          // Unreachable encodings fall back to a safe, unaddressed state.
          state_r     <= ST_IDLE;
          index_r     <= 3'd0;
          direction_r <= 1'b0;
          selected_r  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_byte    = tx_byte_r;
  assign direction  = direction_r;
  assign tx_load    = tx_load_r;
  assign selected   = selected_r;
  assign func_byte  = func_byte_r;
  assign func_valid = func_valid_r;

endmodule

// File: doc/onewire_rom_layer.md
# onewire_rom_layer

ROM-command layer of the 1-Wire slave: sits directly downstream of the bit-level slave front end, consuming its received bytes and driving its transmit byte, direction and load strobe. After each bus reset it decodes the ROM command (READ ROM, MATCH ROM, SKIP ROM), addresses the device against a fixed 64-bit ID, and, once the device is selected, forwards function-command bytes to the application. Unselected or unknown-command transactions are ignored until the next bus reset.

## Interface
- `ROM_ID`, default 64'h5A00_0000_0012_3428: device ID. Byte 0 (LSBs) is the family code; byte 7 is the CRC. Supplied complete and not validated.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `line_reset`  in  1  one-cycle pulse from the front end: 1-Wire bus reset/presence completed.
- `rx_byte`  in  8  last received byte from the front end, LSB first on the wire.
- `rx_finished`  in  1  level from the front end; a rising edge marks `rx_byte` as valid.
- `tx_done`  in  1  one-cycle pulse from the front end: the current `tx_byte` has been fully shifted out.
- `tx_byte`  out  8  byte for the front end to transmit.
- `direction`  out  1  1 = device transmits, 0 = device receives.
- `tx_load`  out  1  one-cycle pulse: `tx_byte` is valid and must be latched.
- `selected`  out  1  device is addressed; function phase is active.
- `func_byte`  out  8  function/data byte received while selected.
- `func_valid`  out  1  one-cycle pulse qualifying `func_byte`.

## Operation
- **rx edge detection:** `rx_finished` is registered once per cycle. A new byte event (`rx_ev`) is asserted when `rx_finished`=1 and its registered copy=0.
- **States:**
  - `IDLE`: entered after `reset`.
  - `ROM_CMD`: waits for the ROM command byte. On `rx_ev`:
    - 0x33 → `READ_ROM`
    - 0x55 → `MATCH_ROM`
    - 0xCC → `SELECTED`
    - any other value → `DESELECTED`
  - `READ_ROM`: on entry, index=0, `tx_byte`=ROM_ID[7:0], `direction`=1, `tx_load` pulses.
    - Each `tx_done` increments the index, then loads and pulses the next byte.
    - On `tx_done` at index 7: `direction`=0, go to `SELECTED`.
  - `MATCH_ROM`: index counts from 0 to 7. On each `rx_ev`, `rx_byte` is compared with ROM_ID byte[index].
    - First mismatch → `DESELECTED` immediately.
    - Match at index 7 → `SELECTED`.
  - `SELECTED`: `selected`=1. Each `rx_ev` sets `func_byte`=`rx_byte` and pulses `func_valid`.
  - `DESELECTED`: ignores `rx_ev` and `tx_done`.
- **Bus reset:** `line_reset` in any state forces `ROM_CMD` and clears `direction`, `selected` and the index. `IDLE` also leaves only on `line_reset`.
- **Index:** 3-bit counter with no wrap-around use. Exit from the state occurs at 7.
- **Ignored inputs:**
  - `tx_done` outside `READ_ROM`.
  - `rx_ev` in `IDLE`, `READ_ROM` and `DESELECTED`.

## Timing
- **Reset values:** `tx_byte`=0, `direction`=0, `tx_load`=0, `selected`=0, `func_byte`=0, `func_valid`=0; state=`IDLE`; index=0; rx edge register=0.
- **rx decode latency:** `rx_finished` rises in cycle N; `rx_ev` in N+1; state and outputs update at the end of N+1, visible in N+2.
- **`func_valid`:** visible in N+2, exactly one cycle wide.
- **READ ROM start:** `tx_load` and `direction`=1 are visible the cycle after entering `READ_ROM`.
- **READ ROM per byte:** `tx_done` in cycle M → next `tx_byte` plus `tx_load` in M+1.
- **Simultaneous events:**
  - `line_reset` with `rx_ev` or `tx_done`: `line_reset` wins and the event is dropped.
  - `reset` overrides everything.
- **Reset mid-operation:** `reset` asserted mid-`READ_ROM` returns to `IDLE` with `direction`=0 the next cycle.
- **Throughput:** back-to-back `rx_ev` on consecutive cycles must be handled.

## Structure
- **Shared package `onewire_pkg`:**
  - ROM command constants `CMD_READ_ROM`=0x33, `CMD_MATCH_ROM`=0x55, `CMD_SKIP_ROM`=0xCC.
  - State encoding constants.
- **Sub-module `onewire_edge_detect`:** rising-edge pulse from a level, reusable for other front-end levels.
- **Top level:** the remainder (FSM, index, ID byte mux) is a single always block plus output registers.

## Test plan
- **Reset values:** assert `reset` for 2 cycles → all outputs 0, `selected`=0; a subsequent `rx_ev` of 0xCC without `line_reset` → no state change.
- **SKIP ROM:** `line_reset`, rx 0xCC, rx 0x44 → `selected`=1, one `func_valid` with `func_byte`=0x44.
- **READ ROM:** `line_reset`, rx 0x33, then 8 `tx_done` pulses → 8 `tx_load` pulses carrying 28,34,12,00,00,00,00,5A in that order; then `direction`=0 and `selected`=1.
- **MATCH ROM:**
  - Correct ID (28,34,12,00,00,00,00,5A) → `selected`=1.
  - Bad ID with byte 2 = 0x13 → `DESELECTED`; later rx 0x44 gives no `func_valid`.
- **Unknown command:** `line_reset`, rx 0xF0 → `selected` stays 0; a following rx produces no `func_valid`.
- **Bus reset mid-transfer:** `line_reset` after 3 READ ROM bytes → `direction`=0 next cycle; rx 0xCC → `selected`=1.
- **Collision:** `line_reset` in the same cycle as `tx_done` → no further `tx_load`.
